// File: rtl/elastic_buffer_pkg.sv
// Shared constants and helpers for the SKP elastic buffer.
// SKP codes are K28.0 in both running disparities.
package elastic_buffer_pkg;

  localparam int SYM_W = 10;

  localparam logic [SYM_W-1:0] SKP_RDN_DEF = 10'h0F4;
  localparam logic [SYM_W-1:0] SKP_RDP_DEF = 10'h30B;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic logic is_skp(
    input logic [SYM_W-1:0] sym,
    input logic [SYM_W-1:0] rdn,
    input logic [SYM_W-1:0] rdp
  );
    return (sym == rdn) || (sym == rdp);
  endfunction

endpackage

// File: rtl/elastic_buffer_mem.sv
// Elastic buffer storage: register array with one write port
// and one combinational read port; storage is never reset.
module elastic_buffer_mem #(
  parameter int DATA_WIDTH = 10,
  parameter int DEPTH      = 16,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/elastic_buffer_skp.sv
// RX elastic buffer with SKP removal above HI_WM and SKP replay
// below LO_WM; decisions use start-of-cycle occupancy.
module elastic_buffer_skp
  import elastic_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int DEPTH      = 16,
  parameter int HI_WM      = 12,
  parameter int LO_WM      = 4,
  parameter logic [DATA_WIDTH-1:0] SKP_RDN = SKP_RDN_DEF,
  parameter logic [DATA_WIDTH-1:0] SKP_RDP = SKP_RDP_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_valid,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic                       rd_en,
  input  logic                       clr_err,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       rd_valid,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       skp_removed,
  output logic                       skp_added,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] HI = PW'(HI_WM);
  localparam logic [PW-1:0] LO = PW'(LO_WM);
  localparam logic [PW-1:0] ONE = PW'(1);

  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic [PW-1:0]         occ;
  logic [DATA_WIDTH-1:0] head;
  logic                  replayed;

  logic wr_skp;
  logic head_skp;
  logic drop_skp;
  logic do_wr;
  logic ovf_set;
  logic do_rd;
  logic unf_set;
  logic replay;
  logic adv;

  assign occ   = wptr - rptr;
  assign empty = (wptr == rptr);
  assign full  = (wptr[PW-1] != rptr[PW-1])
              && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign occupancy = occ;

  assign wr_skp   = is_skp(wr_data, SKP_RDN, SKP_RDP);
  assign head_skp = is_skp(head, SKP_RDN, SKP_RDP);

  assign ovf_set  = wr_valid && full;
  assign drop_skp = wr_valid && !full && wr_skp && (occ > HI);
  assign do_wr    = wr_valid && !full && !drop_skp;

  assign unf_set = rd_en && empty;
  assign do_rd   = rd_en && !empty;
  // A stored SKP may be emitted a second time only once.
  assign replay  = do_rd && head_skp && (occ < LO) && !replayed;
  assign adv     = do_rd && !replay;

  elastic_buffer_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk   (clk),
    .we    (do_wr),
    .waddr (wptr[AW-1:0]),
    .wdata (wr_data),
    .raddr (rptr[AW-1:0]),
    .rdata (head)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr        <= '0;
      rptr        <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      replayed    <= 1'b0;
      skp_removed <= 1'b0;
      skp_added   <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      if (do_wr) wptr <= wptr + ONE;
      if (adv)   rptr <= rptr + ONE;
      if (do_rd) begin
        rd_data  <= head;
        replayed <= replay;
      end
      rd_valid    <= do_rd;
      skp_removed <= drop_skp;
      skp_added   <= replay;
      overflow    <= ovf_set | (overflow & ~clr_err);
      underflow   <= unf_set | (underflow & ~clr_err);
    end
  end

endmodule
